rec_play_ctrl: RTL

//  Top-level sequencer of the audio recorder. Turns record/play/stop button pulses into a

---
 rtl/rec_play_if.sv | 23 ++
 rtl/rec_play_ctrl.sv | 79 +++++++
 2 files changed

// File: rtl/rec_play_if.sv
// rec_play_if: button, timer and sample-memory signals of the record/playback sequencer
interface rec_play_if #(parameter int ADDR_W = 14);
  logic              rec_btn_i;
  logic              play_btn_i;
  logic              stop_btn_i;
  logic              sample_tick_i;
  logic              timer_done_i;
  logic              timer_reset_o;
  logic              mem_we_o;
  logic              mem_re_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [ADDR_W:0]   rec_len_o;
  logic [2:0]        state_o;
  logic              busy_o;
  modport slave (
    input  rec_btn_i, play_btn_i, stop_btn_i, sample_tick_i, timer_done_i,
    output timer_reset_o, mem_we_o, mem_re_o, mem_addr_o, rec_len_o, state_o, busy_o
  );
  modport master (
    output rec_btn_i, play_btn_i, stop_btn_i, sample_tick_i, timer_done_i,
    input  timer_reset_o, mem_we_o, mem_re_o, mem_addr_o, rec_len_o, state_o, busy_o
  );
endinterface

// File: rtl/rec_play_ctrl.sv
// rec_play_ctrl: record/playback session sequencer driving sample-rate memory strobes
module rec_play_ctrl #(
  parameter int ADDR_W      = 14,
  parameter int MAX_SAMPLES = 16384
) (
  input  logic       clk,
  input  logic       reset,
  rec_play_if.slave  bus
);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REC_ARM  = 3'd1,
    REC      = 3'd2,
    PLAY_ARM = 3'd3,
    PLAY     = 3'd4
  } state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MAX_SAMPLES - 1);
  localparam logic [ADDR_W:0]   FULL = (ADDR_W + 1)'(MAX_SAMPLES);
  state_t            state;
  logic              we, re, tr;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   rec_len, addr_x, addr_n;
  assign addr_x = {1'b0, addr};
  assign addr_n = addr_x + 1'b1;
  // Session FSM: strobes last one cycle, so a tick seen while a strobe is high is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      we      <= 1'b0;
      re      <= 1'b0;
      tr      <= 1'b0;
      addr    <= '0;
      rec_len <= '0;
    end else begin
      tr <= 1'b0;
      we <= 1'b0;
      re <= 1'b0;
      case (state)
        IDLE:
          if (bus.rec_btn_i) begin
            state <= REC_ARM;
            tr    <= 1'b1;
          end else if (bus.play_btn_i && rec_len != '0) begin
            state <= PLAY_ARM;
            tr    <= 1'b1;
          end
        REC_ARM: begin
          state <= REC;
          addr  <= '0;
        end
        PLAY_ARM: begin
          state <= PLAY;
          addr  <= '0;
        end
        REC:
          if (bus.stop_btn_i || bus.timer_done_i) begin
            state   <= IDLE;
            rec_len <= addr_x + {{ADDR_W{1'b0}}, we};
          end else if (we && addr == LAST) begin
            state   <= IDLE;
            rec_len <= FULL;
          end else if (we) addr <= addr + 1'b1;
          else we <= bus.sample_tick_i;
        PLAY:
          if (bus.stop_btn_i || (re && addr_n == rec_len)) state <= IDLE;
          else if (re) addr <= addr + 1'b1;
          else re <= bus.sample_tick_i;
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.timer_reset_o = tr;
  assign bus.mem_we_o      = we;
  assign bus.mem_re_o      = re;
  assign bus.mem_addr_o    = addr;
  assign bus.rec_len_o     = rec_len;
  assign bus.state_o       = state;
  assign bus.busy_o        = state != IDLE;
endmodule
